// File: rtl/wr_bank_if.sv
// Handshake and bank-status bundle between the writer/reader side and wr_bank_ctrl.
interface wr_bank_if #(
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned BANK_DEPTH = 16
);
    localparam int unsigned BW = $clog2(NUM_BANKS);
    localparam int unsigned AW = $clog2(BANK_DEPTH);

    logic                 wr_valid;
    logic                 wr_flush;
    logic [NUM_BANKS-1:0] bank_lock;
    logic                 wr_ready;
    logic [BW-1:0]        wr_bank;
    logic [AW-1:0]        wr_addr;
    logic [NUM_BANKS-1:0] bank_sel;
    logic [NUM_BANKS-1:0] bank_done;
    logic [AW:0]          done_count;
    logic                 wait_st;

    modport master (
        output wr_valid, wr_flush, bank_lock,
        input  wr_ready, wr_bank, wr_addr, bank_sel, bank_done, done_count, wait_st
    );

    modport slave (
        input  wr_valid, wr_flush, bank_lock,
        output wr_ready, wr_bank, wr_addr, bank_sel, bank_done, done_count, wait_st
    );
endinterface

// File: rtl/wr_bank_ctrl.sv
// Write-side bank controller: fills banks, closes them on full/flush, hands them to the reader
// and advances in strict rotation or to the first free bank, stalling while candidates are locked.
module wr_bank_ctrl #(
    parameter int unsigned NUM_BANKS    = 2,
    parameter int unsigned BANK_DEPTH   = 16,
    parameter bit          STRICT_ORDER = 1'b1
) (
    input logic        clk,
    input logic        rst,
    wr_bank_if.slave   bus
);
    localparam int unsigned BW = $clog2(NUM_BANKS);
    localparam int unsigned AW = $clog2(BANK_DEPTH);

    typedef enum logic {StWrite, StWait} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] cur_q, cur_d;
    logic [AW-1:0] ptr_q, ptr_d;

    logic          accept, close;
    logic [BW:0]   search;
    logic [BW-1:0] cand;
    logic          cand_ok;

    function automatic logic [BW-1:0] inc_bank(input logic [BW-1:0] b);
        return (b == BW'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
    endfunction

    // Cyclic search from cur+1; cur itself is only a candidate when incl_self is set.
    function automatic logic [BW:0] find_free(input logic [BW-1:0]        cur,
                                              input logic [NUM_BANKS-1:0] lock,
                                              input logic                 incl_self);
        logic [BW:0] res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 1; k <= NUM_BANKS; k++) begin
            idx = 32'(cur) + k;
            if (idx >= NUM_BANKS) idx -= NUM_BANKS;
            if (!res[BW] && (k < NUM_BANKS || incl_self) && !lock[idx[BW-1:0]]) begin
                res = {1'b1, idx[BW-1:0]};
            end
        end
        return res;
    endfunction

    always_comb begin
        accept  = (state_q == StWrite) && bus.wr_valid;
        close   = (state_q == StWrite) &&
                  ((accept && (ptr_q == AW'(BANK_DEPTH - 1))) ||
                   (bus.wr_flush && ((ptr_q != '0) || accept)));
        search  = find_free(cur_q, bus.bank_lock, state_q == StWait);
        // In strict mode WAIT, cur_q already holds the target bank.
        if (STRICT_ORDER) begin
            cand    = (state_q == StWrite) ? inc_bank(cur_q) : cur_q;
            cand_ok = !bus.bank_lock[cand];
        end else begin
            cand    = search[BW-1:0];
            cand_ok = search[BW];
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StWrite: begin
                if (close) begin
                    ptr_d = '0;
                    if (cand_ok) begin
                        cur_d = cand;
                    end else begin
                        state_d = StWait;
                        if (STRICT_ORDER) cur_d = cand;
                    end
                end else if (accept) begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StWait: begin
                if (cand_ok) begin
                    state_d = StWrite;
                    cur_d   = cand;
                    ptr_d   = '0;
                end
            end
            default: state_d = StWrite;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StWrite;
            cur_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        bus.wr_ready   = (state_q == StWrite);
        bus.wait_st    = (state_q == StWait);
        bus.wr_bank    = cur_q;
        bus.wr_addr    = ptr_q;
        bus.bank_sel   = (state_q == StWrite) ? (NUM_BANKS'(1) << cur_q) : '0;
        bus.bank_done  = close ? (NUM_BANKS'(1) << cur_q) : '0;
        bus.done_count = close ? ({1'b0, ptr_q} + {{AW{1'b0}}, accept}) : '0;
    end
endmodule

// File: tb/tb_wr_bank_ctrl.sv
// Self-checking bench for wr_bank_ctrl across four configurations with a bank_done scoreboard.
module tb_wr_bank_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] qc[$];
    logic [31:0] qd[$];

    // a: 4x4 strict, b: 2x4 strict, c: 4x4 first-free, d: 3x4 strict
    wr_bank_if #(.NUM_BANKS(4), .BANK_DEPTH(4)) ifa ();
    wr_bank_if #(.NUM_BANKS(2), .BANK_DEPTH(4)) ifb ();
    wr_bank_if #(.NUM_BANKS(4), .BANK_DEPTH(4)) ifc ();
    wr_bank_if #(.NUM_BANKS(3), .BANK_DEPTH(4)) ifd ();

    wr_bank_ctrl #(.NUM_BANKS(4), .BANK_DEPTH(4), .STRICT_ORDER(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa));
    wr_bank_ctrl #(.NUM_BANKS(2), .BANK_DEPTH(4), .STRICT_ORDER(1'b1)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb));
    wr_bank_ctrl #(.NUM_BANKS(4), .BANK_DEPTH(4), .STRICT_ORDER(1'b0)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc));
    wr_bank_ctrl #(.NUM_BANKS(3), .BANK_DEPTH(4), .STRICT_ORDER(1'b1)) dut_d (
        .clk(clk), .rst(rst), .bus(ifd));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every bank_done pulse must match the next expected {bank_done, done_count}.
    always @(negedge clk) begin
        if (!rst && ifa.bank_done != '0) begin
            if (qa.size() == 0) check("a_unexpected_done", 32'(ifa.bank_done), 32'd0);
            else check("a_done", 32'({ifa.bank_done, ifa.done_count}), qa.pop_front());
        end
        if (!rst && ifb.bank_done != '0) begin
            if (qb.size() == 0) check("b_unexpected_done", 32'(ifb.bank_done), 32'd0);
            else check("b_done", 32'({ifb.bank_done, ifb.done_count}), qb.pop_front());
        end
        if (!rst && ifc.bank_done != '0) begin
            if (qc.size() == 0) check("c_unexpected_done", 32'(ifc.bank_done), 32'd0);
            else check("c_done", 32'({ifc.bank_done, ifc.done_count}), qc.pop_front());
        end
        if (!rst && ifd.bank_done != '0) begin
            if (qd.size() == 0) check("d_unexpected_done", 32'(ifd.bank_done), 32'd0);
            else check("d_done", 32'({ifd.bank_done, ifd.done_count}), qd.pop_front());
        end
    end

    initial begin
        ifa.wr_valid = 0; ifa.wr_flush = 0; ifa.bank_lock = '0;
        ifb.wr_valid = 0; ifb.wr_flush = 0; ifb.bank_lock = '0;
        ifc.wr_valid = 0; ifc.wr_flush = 0; ifc.bank_lock = '0;
        ifd.wr_valid = 0; ifd.wr_flush = 0; ifd.bank_lock = '0;
        rst = 1;
        step();
        step();
        rst = 0;
        #1;

        // Reset state
        check("rst_ready", 32'(ifa.wr_ready), 32'd1);
        check("rst_bank", 32'(ifa.wr_bank), 32'd0);
        check("rst_addr", 32'(ifa.wr_addr), 32'd0);
        check("rst_sel", 32'(ifa.bank_sel), 32'b0001);
        check("rst_done", 32'(ifa.bank_done), 32'd0);
        check("rst_count", 32'(ifa.done_count), 32'd0);
        check("rst_wait", 32'(ifa.wait_st), 32'd0);
        check("rst_b_sel", 32'(ifb.bank_sel), 32'b01);

        // Strict 4x4: 16 back-to-back writes
        for (int i = 0; i < 16; i++) begin
            ifa.wr_valid = 1;
            #1;
            check("a_ready", 32'(ifa.wr_ready), 32'd1);
            check("a_bank", 32'(ifa.wr_bank), 32'(i / 4));
            check("a_addr", 32'(ifa.wr_addr), 32'(i % 4));
            check("a_sel", 32'(ifa.bank_sel), 32'(4'b0001 << (i / 4)));
            if (i % 4 == 3) qa.push_back(32'({4'b0001 << (i / 4), 3'd4}));
            step();
        end
        ifa.wr_valid = 0;
        #1;
        check("a_wrap_bank", 32'(ifa.wr_bank), 32'd0);
        check("a_wrap_addr", 32'(ifa.wr_addr), 32'd0);

        // Strict 2x4 with bank 1 locked: fill bank 0 then stall
        ifb.bank_lock = 2'b10;
        for (int i = 0; i < 4; i++) begin
            ifb.wr_valid = 1;
            if (i == 3) qb.push_back(32'({2'b01, 3'd4}));
            step();
        end
        ifb.wr_valid = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("b_wait_ready", 32'(ifb.wr_ready), 32'd0);
            check("b_wait_st", 32'(ifb.wait_st), 32'd1);
            check("b_wait_sel", 32'(ifb.bank_sel), 32'd0);
            check("b_wait_bank", 32'(ifb.wr_bank), 32'd1);
            step();
        end
        ifb.wr_valid  = 0;
        ifb.bank_lock = 2'b00;
        #1;
        check("b_still_wait", 32'(ifb.wait_st), 32'd1);
        step();
        check("b_exit_ready", 32'(ifb.wr_ready), 32'd1);
        check("b_exit_bank", 32'(ifb.wr_bank), 32'd1);
        check("b_exit_addr", 32'(ifb.wr_addr), 32'd0);

        // First-free 4x4 with bank 1 locked: bank 0 -> bank 2
        ifc.bank_lock = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            ifc.wr_valid = 1;
            if (i == 3) qc.push_back(32'({4'b0001, 3'd4}));
            step();
        end
        ifc.wr_valid = 0;
        #1;
        check("c_skip_bank", 32'(ifc.wr_bank), 32'd2);
        check("c_skip_ready", 32'(ifc.wr_ready), 32'd1);
        // Close bank 2 with 3, 0, 1 locked: WAIT on last bank
        ifc.bank_lock = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            ifc.wr_valid = 1;
            if (i == 3) qc.push_back(32'({4'b0100, 3'd4}));
            step();
        end
        ifc.wr_valid  = 0;
        ifc.bank_lock = 4'b1111;
        #1;
        check("c_wait_st", 32'(ifc.wait_st), 32'd1);
        check("c_wait_bank", 32'(ifc.wr_bank), 32'd2);
        step();
        check("c_wait_hold", 32'(ifc.wait_st), 32'd1);
        ifc.bank_lock = 4'b1110;
        step();
        check("c_exit_bank", 32'(ifc.wr_bank), 32'd0);
        check("c_exit_ready", 32'(ifc.wr_ready), 32'd1);

        // Strict 3x4: index wraps 2 -> 0
        for (int i = 0; i < 12; i++) begin
            ifd.wr_valid = 1;
            #1;
            check("d_bank", 32'(ifd.wr_bank), 32'(i / 4));
            if (i % 4 == 3) qd.push_back(32'({3'b001 << (i / 4), 3'd4}));
            step();
        end
        ifd.wr_valid = 0;
        #1;
        check("d_wrap_bank", 32'(ifd.wr_bank), 32'd0);

        // Flush: 3 writes then flush alone
        for (int i = 0; i < 3; i++) begin
            ifa.wr_valid = 1;
            step();
        end
        ifa.wr_valid = 0;
        ifa.wr_flush = 1;
        qa.push_back(32'({4'b0001, 3'd3}));
        step();
        // Flush at ptr 0 is ignored
        #1;
        check("a_flush0_done", 32'(ifa.bank_done), 32'd0);
        step();
        ifa.wr_flush = 0;
        #1;
        check("a_flush0_bank", 32'(ifa.wr_bank), 32'd1);
        ifa.wr_valid = 1;
        step();
        ifa.wr_flush = 1;
        qa.push_back(32'({4'b0010, 3'd2}));
        step();
        ifa.wr_valid = 0;
        ifa.wr_flush = 0;
        #1;
        check("a_flushw_bank", 32'(ifa.wr_bank), 32'd2);
        check("a_flushw_addr", 32'(ifa.wr_addr), 32'd0);

        // Mid-bank reset
        ifa.wr_valid = 1;
        step();
        step();
        ifa.wr_valid = 0;
        #1;
        check("a_pre_rst_addr", 32'(ifa.wr_addr), 32'd2);
        rst = 1;
        step();
        rst = 0;
        #1;
        check("a_rst_bank", 32'(ifa.wr_bank), 32'd0);
        check("a_rst_addr", 32'(ifa.wr_addr), 32'd0);
        check("a_rst_done", 32'(ifa.bank_done), 32'd0);
        step();

        check("a_q_empty", 32'(qa.size()), 32'd0);
        check("b_q_empty", 32'(qb.size()), 32'd0);
        check("c_q_empty", 32'(qc.size()), 32'd0);
        check("d_q_empty", 32'(qd.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
